// File: rtl/window_gen_5x5.sv
// 5x5 sliding-window generator: buffers four previous lines of a raster pixel
// stream and emits a registered 5x5 neighbourhood per accepted pixel.
module window_gen_5x5 #(
    parameter int unsigned IMG_W = 516,
    parameter int unsigned IMG_H = 516,
    parameter int unsigned PIX_W = 10,
    parameter int unsigned IDX_W = 19
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             pix_in,
    input  logic                   pix_valid,
    output logic [25*PIX_W-1:0]    win_out,
    output logic                   win_valid,
    output logic [IDX_W-1:0]       win_index,
    output logic                   frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned N_LB  = 4;
    localparam int unsigned N_TAP = 25;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PIX_W-1:0] win_q [N_TAP];
    logic [PIX_W-1:0] win_d [N_TAP];
    logic             win_valid_q, win_valid_d;
    logic [IDX_W-1:0] win_index_q, win_index_d;
    logic             frame_done_q, frame_done_d;

    logic [7:0]       lb_mem [N_LB][IMG_W];
    logic [7:0]       lb_rd  [N_LB];
    logic [PIX_W-1:0] new_col [5];
    logic             col_last, row_last, win_ok;

    // Line-buffer read at the current column, before this cycle's write lands
    always_comb begin
        for (int i = 0; i < int'(N_LB); i++) begin
            lb_rd[i] = lb_mem[i][col_q];
        end
    end

    always_comb begin
        for (int i = 0; i < int'(N_LB); i++) begin
            new_col[i] = PIX_W'(lb_rd[i]);
        end
        new_col[4] = PIX_W'(pix_in);
    end

    assign col_last = (col_q == COL_W'(IMG_W - 1));
    assign row_last = (row_q == ROW_W'(IMG_H - 1));
    assign win_ok   = (row_q >= ROW_W'(4)) && (col_q >= COL_W'(4));

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        win_index_d  = win_index_q;
        for (int k = 0; k < int'(N_TAP); k++) begin
            win_d[k] = win_q[k];
        end

        if (pix_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end

            // Shift every row left; the freshly assembled column enters at column 4
            for (int k = 0; k < int'(N_TAP); k++) begin
                if ((k % 5) == 4) begin
                    win_d[k] = new_col[k / 5];
                end else begin
                    win_d[k] = win_q[k + 1];
                end
            end

            if (win_ok) begin
                win_valid_d = 1'b1;
                win_index_d = ((row_q == ROW_W'(4)) && (col_q == COL_W'(4)))
                              ? '0 : win_index_q + IDX_W'(1);
            end
            frame_done_d = col_last && row_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_index_q  <= '0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < int'(N_TAP); k++) begin
                win_q[k] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            win_index_q  <= win_index_d;
            frame_done_q <= frame_done_d;
            for (int k = 0; k < int'(N_TAP); k++) begin
                win_q[k] <= win_d[k];
            end
        end
    end

    // Line buffers are not cleared; stale entries never reach a valid window
    always_ff @(posedge clk) begin
        if (!rst && pix_valid) begin
            for (int i = 0; i < int'(N_LB) - 1; i++) begin
                lb_mem[i][col_q] <= lb_rd[i + 1];
            end
            lb_mem[N_LB-1][col_q] <= pix_in;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(N_TAP); k++) begin
            win_out[k*PIX_W +: PIX_W] = win_q[k];
        end
    end

    assign win_valid  = win_valid_q;
    assign win_index  = win_index_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/window_gen_5x5.md
Name: window_gen_5x5

Overview:
- Upstream stage of the 5x5 Gabor convolution unit.
- Accepts a raster-order 8-bit pixel stream of a padded image, buffers four previous lines, and presents a full 5x5 neighbourhood each accepted pixel once the neighbourhood is complete.
- Outputs are the 25 zero-extended 10-bit taps plus a valid strobe and a linear window index. The index matches the addressing of the 512x512 output image for the default 516x516 padded frame.

Parameters:
- IMG_W, 516, padded line width in pixels (min 5).
- IMG_H, 516, padded frame height in lines (min 5).
- PIX_W, 10, width of each output tap; input is zero-extended to this width.
- IDX_W, 19, width of win_index; must hold (IMG_W-4)*(IMG_H-4)-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_in  in  8  incoming pixel, raster order, line 0 column 0 first.
- pix_valid  in  1  pix_in is accepted on every rising edge where this is high; there is no backpressure.
- win_out  out  25*PIX_W  flattened window; tap k (k=0..24) occupies bits [PIX_W*k+PIX_W-1 : PIX_W*k]. Tap k is row k/5, column k%5; tap 0 is top-left (conv unit pixel1), tap 24 is bottom-right (pixel25).
- win_valid  out  1  one-cycle strobe: win_out and win_index are valid.
- win_index  out  IDX_W  linear output index (r-4)*(IMG_W-4)+(c-4).
- frame_done  out  1  one-cycle pulse, registered alongside the acceptance of the last pixel of a frame.

Behaviour:
- Reset, synchronous: col=0, row=0, win_valid=0, frame_done=0, win_index=0, and all 25 window registers set to 0. Line-buffer RAM is not cleared; stale contents are masked by valid gating.
- Counters: col advances 0..IMG_W-1 per accepted pixel. When col reaches IMG_W-1 it wraps to 0 and row increments. At row=IMG_H-1, col=IMG_W-1, both wrap to 0 and a new frame begins with no idle cycle required.
- Line buffers: four lines of IMG_W entries, addressed by col.
  - On accepting pixel (r,c), read LB0..LB3 at c. These hold the pixels at (r-4,c)..(r-1,c).
  - Write the shift-up into the same entries: LB0<=LB1, LB1<=LB2, LB2<=LB3, LB3<=pix_in.
  - The read-before-write ordering within one cycle is mandatory. Either a register array or a RAM with read-first behaviour is acceptable.
- Window: on each accepted pixel, all rows shift left by one column. The new column {LB0,LB1,LB2,LB3,pix_in} enters column 4, rows 0..4.
  - If pix_valid is low, the window, counters and buffers hold.
- Output timing: outputs are registered, with latency 1 cycle from acceptance.
  - win_valid=1 in the cycle after accepting (r,c) iff r>=4 and c>=4. win_out then holds image pixels (r-4..r, c-4..c).
  - win_valid=0 in every other cycle, including all cycles following a pix_valid=0 cycle.
- Row wrap: columns 0..3 of a new line leave stale columns from the previous line in the window. These are never flagged valid, because c>=4 is required.
- win_index: increments by 1 on each win_valid and returns to 0 for the first window of each frame. Windows per frame = (IMG_W-4)*(IMG_H-4), which is 262144 at default parameters.
- frame_done: asserted in the same cycle as the final win_valid of the frame.
- Reset mid-frame: takes effect on the next edge. Any in-flight win_valid is suppressed. The next accepted pixel is treated as (0,0). No valid window appears until 4*IMG_W+5 pixels have been accepted.
- rst and pix_valid high on the same edge: rst wins and the pixel is dropped.

Test Plan:
1. IMG_W=IMG_H=8, pixel(r,c)=(7r+c)&255, pix_valid continuously high -> first win_valid one cycle after pixel (4,4) is accepted, which is the 37th accepted pixel. win_index=0, tap0=0, tap4=4, tap20=28, tap24=32, upper two bits of each tap zero.
2. Same image streamed in full -> exactly 16 win_valid pulses with win_index 0..15 in order. The last window has tap24=(7*7+7)=56. frame_done coincides with win_index=15.
3. Same image with pix_valid toggling 1,0,1,0,... -> identical window sequence and contents as scenario 1. win_valid is never asserted in the cycle after a pix_valid=0 cycle.
4. Two back-to-back frames with no gap -> second frame restarts win_index at 0. Its first window must not contain any first-frame pixels in rows 0..3 beyond the values freshly written; check tap0 against the frame-2 value of pixel (0,0).
5. rst pulsed for 1 cycle after 20 accepted pixels, then a full frame -> no win_valid until the 37th post-reset pixel, then 16 windows identical to scenario 2.
6. Default parameters, 516x516 ramp image -> 262144 win_valid pulses, final win_index=262143, one frame_done pulse.
